// File: rtl/seq_comparator.sv
// Registered magnitude/equality comparator with hit counting and run-length lock.
// Define SEQCMP_SIGNED_EN to make gt/lt compare two's-complement signed values.
module seq_comparator #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] b,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  output logic             valid_out,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             hit,
  output logic             lock,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int RUN_W = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   ref_word;
  logic [RUN_W-1:0]   run;
  logic [RUN_W-1:0]   run_inc;
  logic               a_eq;
  logic               a_gt;
  logic               a_lt;
  logic               hit_now;

  assign a_eq    = (a == ref_word);
  assign run_inc = run + 1'b1;

`ifdef SEQCMP_SIGNED_EN
  assign a_gt = ($signed(a) > $signed(ref_word));
  assign a_lt = ($signed(a) < $signed(ref_word));
`else
  assign a_gt = (a > ref_word);
  assign a_lt = (a < ref_word);
`endif

  always_comb begin
    hit_now = 1'b0;
    case (mode)
      2'b00:   hit_now = a_eq;
      2'b01:   hit_now = !a_eq;
      2'b10:   hit_now = a_gt;
      2'b11:   hit_now = a_lt;
      default: hit_now = 1'b0;
    endcase
  end

  // Flags always reflect the sample against the pre-edge ref; load only
  // overrides the run/lock/count bookkeeping of a coincident sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_word  <= '0;
      state     <= IDLE;
      run       <= '0;
      valid_out <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      hit       <= 1'b0;
      lock      <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      valid_out <= valid_in;
      hit       <= valid_in & hit_now;
      if (valid_in) begin
        eq <= a_eq;
        gt <= a_gt;
        lt <= a_lt;
      end

      if (load) begin
        ref_word <= b;
        state    <= IDLE;
        run      <= '0;
        lock     <= 1'b0;
        hit_cnt  <= '0;
      end else if (valid_in) begin
        if (hit_now) begin
          if (hit_cnt != {CNT_W{1'b1}}) begin
            hit_cnt <= hit_cnt + 1'b1;
          end
          case (state)
            IDLE: begin
              run <= run_inc;
              if (HOLD == 1) begin
                state <= LOCKED;
                lock  <= 1'b1;
              end else begin
                state <= TRACK;
              end
            end
            TRACK: begin
              run <= run_inc;
              if (run_inc == RUN_W'(HOLD)) begin
                state <= LOCKED;
                lock  <= 1'b1;
              end
            end
            LOCKED: begin
              state <= LOCKED;
            end
            default: begin
              state <= IDLE;
              run   <= '0;
              lock  <= 1'b0;
            end
          endcase
        end else begin
          state <= IDLE;
          run   <= '0;
          lock  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: a default instance and a HOLD=1/CNT_W=2 instance
// share stimulus and are checked each cycle against a streak/total model.
module tb_seq_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] b;
  logic       valid_in;
  logic [7:0] a;
  logic [1:0] mode;

  logic       valid_out, eq, gt, lt, hit, lock;
  logic [7:0] hit_cnt;
  logic       valid_out2, eq2, gt2, lt2, hit2, lock2;
  logic [1:0] hit_cnt2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: ref, length of the current hit streak and hits since load.
  logic [7:0] m_ref;
  int         streak;
  int         total;
  logic       e_vo, e_eq, e_gt, e_lt, e_hit;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(8), .HOLD(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .load(load), .b(b), .valid_in(valid_in), .a(a),
    .mode(mode), .valid_out(valid_out), .eq(eq), .gt(gt), .lt(lt),
    .hit(hit), .lock(lock), .hit_cnt(hit_cnt)
  );

  seq_comparator #(.WIDTH(8), .HOLD(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .load(load), .b(b), .valid_in(valid_in), .a(a),
    .mode(mode), .valid_out(valid_out2), .eq(eq2), .gt(gt2), .lt(lt2),
    .hit(hit2), .lock(lock2), .hit_cnt(hit_cnt2)
  );

  always @(posedge clk or posedge rst) begin
    int av, rv;
    if (rst) begin
      m_ref = 8'h00; streak = 0; total = 0;
      e_vo = 0; e_eq = 0; e_gt = 0; e_lt = 0; e_hit = 0;
    end else begin
      e_vo  = valid_in;
      e_hit = 1'b0;
      if (valid_in) begin
        av = int'(a);
        rv = int'(m_ref);
`ifdef SEQCMP_SIGNED_EN
        if (av >= 128) av = av - 256;
        if (rv >= 128) rv = rv - 256;
`endif
        e_eq = (av == rv);
        e_gt = (av > rv);
        e_lt = (av < rv);
        case (mode)
          2'd0: e_hit = (av == rv);
          2'd1: e_hit = (av != rv);
          2'd2: e_hit = (av > rv);
          default: e_hit = (av < rv);
        endcase
      end
      if (load) begin
        m_ref = b; streak = 0; total = 0;
      end else if (valid_in) begin
        if (e_hit) begin
          streak++; total++;
        end else begin
          streak = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      checkOutput("valid_out", 32'(valid_out), 32'(e_vo));
      checkOutput("eq",        32'(eq),        32'(e_eq));
      checkOutput("gt",        32'(gt),        32'(e_gt));
      checkOutput("lt",        32'(lt),        32'(e_lt));
      checkOutput("hit",       32'(hit),       32'(e_hit));
      checkOutput("lock",      32'(lock),      32'(streak >= 3));
      checkOutput("hit_cnt",   32'(hit_cnt),   32'((total > 255) ? 255 : total));
      checkOutput("valid_out2", 32'(valid_out2), 32'(e_vo));
      checkOutput("eq2",       32'(eq2),       32'(e_eq));
      checkOutput("gt2",       32'(gt2),       32'(e_gt));
      checkOutput("lt2",       32'(lt2),       32'(e_lt));
      checkOutput("hit2",      32'(hit2),      32'(e_hit));
      checkOutput("lock2",     32'(lock2),     32'(streak >= 1));
      checkOutput("hit_cnt2",  32'(hit_cnt2),  32'((total > 3) ? 3 : total));
    end
  end

  // Drive one cycle of inputs and return 1ns after the edge that samples them.
  task automatic applyStimulus(input logic ld, input logic [7:0] bv, input logic vin,
                               input logic [7:0] av, input logic [1:0] md);
    load = ld; b = bv; valid_in = vin; a = av; mode = md;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra;
    rst = 1'b0; load = 0; b = 0; valid_in = 0; a = 0; mode = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    applyStimulus(0, 8'h00, 0, 8'h00, 2'd0);
    applyStimulus(0, 8'h00, 0, 8'h00, 2'd0);
    checkOutput("idle_valid_out", 32'(valid_out), 0);
    checkOutput("idle_flags", {29'd0, eq, gt, lt}, 0);
    checkOutput("idle_hit_lock", {30'd0, hit, lock}, 0);
    checkOutput("idle_hit_cnt", 32'(hit_cnt), 0);

    applyStimulus(1, 8'h5A, 0, 8'h00, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 8'h00, 1, 8'h5A, 2'd0);
      checkOutput("run_eq_hit", {30'd0, eq, hit}, 32'h3);
      checkOutput("run_hit_cnt", 32'(hit_cnt), 32'(i));
      checkOutput("run_lock", 32'(lock), 32'(i >= 3));
      checkOutput("run_hit_cnt2", 32'(hit_cnt2), 32'((i > 3) ? 3 : i));
    end

    applyStimulus(1, 8'h5A, 0, 8'h00, 2'd0);
    applyStimulus(0, 8'h00, 1, 8'h5A, 2'd0);
    applyStimulus(0, 8'h00, 1, 8'h5A, 2'd0);
    applyStimulus(0, 8'h00, 0, 8'h5A, 2'd0);
    checkOutput("gap_lock", 32'(lock), 0);
    checkOutput("gap_valid_hit", {30'd0, valid_out, hit}, 0);
    applyStimulus(0, 8'h00, 1, 8'h5A, 2'd0);
    checkOutput("gap_lock_rise", 32'(lock), 1);
    checkOutput("gap_hit_cnt", 32'(hit_cnt), 3);
    applyStimulus(0, 8'h00, 1, 8'h5B, 2'd0);
    checkOutput("miss_lock", 32'(lock), 0);
    checkOutput("miss_flags", {29'd0, eq, gt, lt}, 32'b010);
    checkOutput("miss_hit_cnt", 32'(hit_cnt), 3);

    applyStimulus(1, 8'h10, 0, 8'h00, 2'd2);
    applyStimulus(0, 8'h00, 1, 8'hF0, 2'd2);
`ifdef SEQCMP_SIGNED_EN
    checkOutput("sign_flags", {29'd0, eq, gt, lt}, 32'b001);
    checkOutput("sign_hit", 32'(hit), 0);
`else
    checkOutput("sign_flags", {29'd0, eq, gt, lt}, 32'b010);
    checkOutput("sign_hit", 32'(hit), 1);
`endif

    applyStimulus(1, 8'h5A, 0, 8'h00, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 8'h00, 1, 8'h5A, 2'd0);
      checkOutput("sat_hit_cnt2", 32'(hit_cnt2), 32'((i > 3) ? 3 : i));
      checkOutput("sat_lock2", 32'(lock2), 1);
    end
    applyStimulus(1, 8'h00, 1, 8'h5A, 2'd0);
    checkOutput("ldhit_flags", {28'd0, valid_out, eq, gt, lt}, 32'b1100);
    checkOutput("ldhit_hit", 32'(hit), 1);
    checkOutput("ldhit_cnt", {22'd0, hit_cnt2, hit_cnt}, 0);
    checkOutput("ldhit_lock", {30'd0, lock2, lock}, 0);
    applyStimulus(0, 8'h00, 1, 8'h5A, 2'd0);
    checkOutput("newref_flags", {29'd0, eq, gt, lt}, 32'b010);

    applyStimulus(1, 8'h5A, 0, 8'h00, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 8'h5A, 2'd0);
    checkOutput("pre_rst_lock", 32'(lock), 1);
    valid_in = 1'b0;
    #3 rst = 1'b1;
    #1;
    checkOutput("async_lock", {30'd0, lock, lock2}, 0);
    checkOutput("async_hit_cnt", 32'(hit_cnt), 0);
    checkOutput("async_valid_out", 32'(valid_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 8'h00, 1, 8'h00, 2'd0);
    checkOutput("post_rst_eq_hit", {30'd0, eq, hit}, 32'h3);
    checkOutput("post_rst_cnt", 32'(hit_cnt), 1);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1: ra = m_ref;
        2: ra = m_ref + 8'd1;
        default: ra = 8'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 3) * 85),
                    ($urandom_range(0, 3) != 0), ra, 2'($urandom_range(0, 3)));
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Registered, parametrised magnitude/equality comparator with match tracking. Each valid sample `a` is compared against a programmable reference word. The block reports registered eq/gt/lt flags, a mode-selected hit, a saturating hit counter, and a lock flag asserted after HOLD consecutive hits. It sits between a data source and control logic that must react to sustained matches rather than single-sample glitches.

## Interface
- `WIDTH`, 8: operand and reference width in bits (≥1).
- `HOLD`, 3: consecutive valid hits required to assert `lock` (≥1).
- `CNT_W`, 8: width of `hit_cnt` (≥1).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: latch `b` into the reference register.
- `b` in WIDTH: reference value, sampled when `load`=1.
- `valid_in` in 1: `a` is a valid sample this cycle.
- `a` in WIDTH: sample operand.
- `mode` in 2: hit condition. 00 = a==ref, 01 = a!=ref, 10 = a>ref, 11 = a<ref.
- `valid_out` out 1: registered flags correspond to a sample.
- `eq`, `gt`, `lt` out 1 each: registered comparison of the last valid sample against ref.
- `hit` out 1: registered mode-selected condition.
- `lock` out 1: HOLD consecutive hits seen.
- `hit_cnt` out CNT_W: total valid hits since reset/load, saturating at all-ones.

## Operation
- The reference register `ref` resets to 0. On `load`=1 it takes `b` at the clock edge.
- On a `valid_in` cycle, `a` is compared against the `ref` value present before that edge.
  - `eq`, `gt`, `lt` are mutually exclusive; exactly one is 1 whenever `valid_out`=1.
  - `hit` is derived from `mode` sampled in the same cycle.
- On a non-valid cycle:
  - `valid_out`=0 and `hit`=0.
  - `eq`, `gt`, `lt` hold their last values.
  - The run counter and FSM are unchanged, so gaps do not break a run.
- FSM states:
  - IDLE (reset): run=0, lock=0. A valid hit goes to TRACK with run=1, or straight to LOCKED if HOLD=1. A valid miss stays in IDLE.
  - TRACK: a valid hit increments run; at run==HOLD go to LOCKED and set lock=1 in that same registered update. A valid miss clears run and returns to IDLE.
  - LOCKED: a valid hit stays. A valid miss clears run and lock and returns to IDLE.
- `load` clears run, lock and hit_cnt and forces IDLE.
  - `load` takes priority over the FSM and counter updates of a simultaneous valid sample.
  - The flags and `valid_out` for that sample are still produced, using the old ref.
- `hit_cnt` increments on each valid hit and saturates at 2^CNT_W−1; it never wraps.
- A mid-stream `mode` change does not reset the run; the next sample is simply evaluated under the new mode.

## Timing
- Latency: one cycle from a `valid_in` edge to `valid_out`, flags, `hit`, `lock` and `hit_cnt`. All outputs are registered.
- Reset values: every output is 0, `ref`=0, FSM=IDLE.
- Asynchronous `rst` mid-run clears everything immediately, without waiting for a clock edge. The first sample after release is evaluated against ref=0.
- `lock` rises on the edge that registers the HOLD-th consecutive valid hit. It falls on the edge that registers the first valid miss or a `load`.
- There is no backpressure: one sample is accepted per cycle.

## Configuration
- `SEQCMP_SIGNED_EN` defined: `gt` and `lt` treat `a` and `ref` as two's-complement signed values.
- `SEQCMP_SIGNED_EN` undefined: unsigned comparison.
- `eq` and modes 00/01 are identical in both builds.

## Test plan
- Reset then idle: all outputs are 0.
- Assert `rst` asynchronously during LOCKED: `lock`, `hit_cnt` and `valid_out` drop before the next clock edge.
- Load b=0x5A, mode=00, then four valid a=0x5A on consecutive cycles:
  - `eq`=1 and `hit`=1 from the first result.
  - `lock` rises with the 3rd result.
  - `hit_cnt` reads 1, 2, 3, 4.
- Same stream with a `valid_in`=0 gap after the 2nd sample: `lock` still rises on the 3rd valid result. Then send a=0x5B: `lock`=0 and `eq`=0, `gt`=1 one cycle later.
- mode=10, ref=0x10, a=0xF0:
  - Unsigned build: `gt`=1, `hit`=1.
  - With `SEQCMP_SIGNED_EN`: `lt`=1, `hit`=0.
- CNT_W=2: 5 valid hits give `hit_cnt` = 1, 2, 3, 3, 3. Then `load` together with a valid hit gives flags for the old ref, with hit_cnt=0 and lock=0 on the next cycle.
